// File: rtl/half_mag_sub_seq_if.sv
// Operand/result handshake bundle for the binary16 magnitude subtractor.
// The master side is the issue logic and the result consumer; the slave side is the subtractor.
interface half_mag_sub_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic        SIGN_A;
   logic        SIGN_B;
   logic [4:0]  IN_EXP_HALF;
   logic [10:0] IN_MANT_A_HALF;
   logic [12:0] IN_MANT_B_HALF;
   logic        STICKY_BIT;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Q;
   logic [4:0]  FLAGS;

   modport master (
      output in_valid, SIGN_A, SIGN_B, IN_EXP_HALF, IN_MANT_A_HALF,
             IN_MANT_B_HALF, STICKY_BIT, out_ready,
      input  in_ready, out_valid, Q, FLAGS
   );

   modport slave (
      input  in_valid, SIGN_A, SIGN_B, IN_EXP_HALF, IN_MANT_A_HALF,
             IN_MANT_B_HALF, STICKY_BIT, out_ready,
      output in_ready, out_valid, Q, FLAGS
   );
endinterface

// File: rtl/half_mag_sub_seq.sv
// Sequential binary16 effective-subtraction datapath: |A-B|, one-bit-per-cycle
// left normalization, round-to-nearest-even, valid/ready on both sides.
module half_mag_sub_seq (
   input  logic              clk,
   input  logic              rst,
   half_mag_sub_seq_if.slave bus
);
   localparam int unsigned DW = 14;
   localparam int unsigned EW = 5;
   localparam int unsigned MW = 11;
   localparam int unsigned RW = MW + 1;
   localparam int unsigned QW = 16;
   localparam int unsigned FW = 5;

   typedef enum logic [2:0] {IDLE, SUB, NORM, ROUND, DONE} state_e;

   state_e          state_q;
   logic            sign_a_q;
   logic            sign_b_q;
   logic            sign_q;
   logic [EW-1:0]   exp_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [DW-1:0]   d_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [QW-1:0]   q_q;
   logic [FW-1:0]   flags_q;

   logic            a_ge_b_c;
   logic [DW-1:0]   diff_d;
   logic            sign_d;
   logic            norm_done_c;

   logic [MW-1:0]   m_c;
   logic            g_c;
   logic            r_c;
   logic            s_c;
   logic            up_c;
   logic            inexact_c;
   logic [RW-1:0]   m_rnd_c;
   logic [MW-1:0]   m_fin_c;
   logic [EW-1:0]   exp_rnd_c;
   logic [EW-1:0]   exp_fld_c;
   logic [QW-1:0]   q_d;
   logic [FW-1:0]   flags_d;

   // Larger magnitude minus smaller; the larger operand supplies the sign.
   always_comb begin
      a_ge_b_c = (a_q >= b_q);
      diff_d   = a_ge_b_c ? (a_q - b_q) : (b_q - a_q);
      sign_d   = a_ge_b_c ? sign_a_q : sign_b_q;
   end

   assign norm_done_c = (d_q == '0) || d_q[DW-1] || (exp_q == EW'(1));

   // RNE on d = {m, G, R, S}; a carry out of m renormalizes to 1.0 at exp+1.
   always_comb begin
      m_c       = d_q[DW-1:3];
      g_c       = d_q[2];
      r_c       = d_q[1];
      s_c       = d_q[0];
      up_c      = g_c & (r_c | s_c | m_c[0]);
      inexact_c = g_c | r_c | s_c;
      m_rnd_c   = {1'b0, m_c} + RW'(up_c);
      if (m_rnd_c[MW]) begin
         m_fin_c   = {1'b1, {(MW-1){1'b0}}};
         exp_rnd_c = exp_q + EW'(1);
      end else begin
         m_fin_c   = m_rnd_c[MW-1:0];
         exp_rnd_c = exp_q;
      end
      exp_fld_c = m_fin_c[MW-1] ? exp_rnd_c : '0;
      q_d       = {sign_q, exp_fld_c, m_fin_c[MW-2:0]};
      flags_d   = {1'b0, (q_d[QW-2:0] == '0), ~d_q[DW-1] & inexact_c, 1'b0, inexact_c};
      if (d_q == '0) begin
         q_d     = '0;
         flags_d = 5'b01000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         d_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         q_q         <= '0;
         flags_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  sign_a_q   <= bus.SIGN_A;
                  sign_b_q   <= bus.SIGN_B;
                  // Subnormal operands share the arithmetic exponent of 1.
                  exp_q      <= (bus.IN_EXP_HALF == '0) ? EW'(1) : bus.IN_EXP_HALF;
                  a_q        <= {bus.IN_MANT_A_HALF, 3'b000};
                  b_q        <= {bus.IN_MANT_B_HALF, bus.STICKY_BIT};
                  in_ready_q <= 1'b0;
                  state_q    <= SUB;
               end
            end
            SUB: begin
               d_q     <= diff_d;
               sign_q  <= sign_d;
               state_q <= NORM;
            end
            NORM: begin
               if (norm_done_c) begin
                  state_q <= ROUND;
               end else begin
                  d_q   <= {d_q[DW-2:0], 1'b0};
                  exp_q <= exp_q - EW'(1);
               end
            end
            ROUND: begin
               q_q         <= q_d;
               flags_q     <= flags_d;
               exp_q       <= exp_rnd_c;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.Q         = q_q;
   assign bus.FLAGS     = flags_q;

endmodule
